// File: rtl/proc_pkg.sv
// Encodings and default bus widths shared between the control unit and the memory responder.
// Holds the responder state type and the word/address width defaults.
package proc_pkg;

    localparam int PROC_ADDR_W = 8;
    localparam int PROC_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM with a registered read port.
// A read updates rdata one edge after en; rdata holds between reads. Contents are never reset.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fetch/load/store responder with a fixed wait latency and a full memory-clear sweep.
// One request per LATENCY+2 cycles; req outside IDLE is dropped, clear is held pending until IDLE.
module mem_responder
    import proc_pkg::*;
#(
    parameter int ADDR_W  = PROC_ADDR_W,
    parameter int DATA_W  = PROC_DATA_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clear,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              clear_done
);

    // One extra pointer bit lets DEPTH == 2**ADDR_W be compared without wrap.
    localparam int              PTR_W   = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);
    localparam logic [3:0]       LAT_P   = 4'(LATENCY);
    localparam bit               LAT0    = (LATENCY == 0);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pending;
    logic [PTR_W-1:0]  ptr;
    logic              rd_oor;

    logic              start_clear;
    logic              accept;
    logic              go_resp;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oor;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign start_clear = (state == ST_IDLE) && (pending || clear);
    assign accept      = (state == ST_IDLE) && !(pending || clear) && req;
    assign go_resp     = (LAT0 && accept) || ((state == ST_WAIT) && (cnt == 4'd1));

    // With zero latency the access happens on the accept edge, so use the live inputs.
    assign acc_we    = (state == ST_IDLE) ? we    : we_q;
    assign acc_addr  = (state == ST_IDLE) ? addr  : addr_q;
    assign acc_wdata = (state == ST_IDLE) ? wdata : wdata_q;
    assign acc_oor   = ({1'b0, acc_addr} >= DEPTH_P);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = acc_addr;
        ram_wdata = acc_wdata;
        if (state == ST_CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = ptr[ADDR_W-1:0];
            ram_wdata = '0;
        end else if (go_resp && !acc_oor) begin
            ram_en = 1'b1;
            ram_we = acc_we;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (ram_en),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rdata   (ram_rdata)
    );

    // An out-of-range read masks the RAM output until the next read response.
    assign rdata = rd_oor ? '0 : ram_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pending    <= 1'b0;
            ptr        <= '0;
            rd_oor     <= 1'b0;
            ready      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            ready      <= 1'b0;
            err        <= 1'b0;
            clear_done <= 1'b0;

            if (clear && ((state == ST_WAIT) || (state == ST_RESP))) begin
                pending <= 1'b1;
            end

            if (go_resp) begin
                ready <= 1'b1;
                err   <= acc_oor;
                if (!acc_we) begin
                    rd_oor <= acc_oor;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start_clear) begin
                        state   <= ST_CLEAR;
                        ptr     <= '0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end else if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= LAT_P;
                        busy    <= 1'b1;
                        state   <= LAT0 ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_CLEAR: begin
                    if (ptr == LAST_P) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        ptr <= ptr + PTR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (default, zero latency, DEPTH=200) driven from a
// vector table with a response scoreboard, plus clear/conflict/reset sequences on the default one.
module tb_mem_responder;

    logic        clock;
    logic        reset_n;
    logic        req_s   [3];
    logic        we_s    [3];
    logic [7:0]  addr_s  [3];
    logic [15:0] wdata_s [3];
    logic        clear_s [3];
    logic        ready_s [3];
    logic [15:0] rdata_s [3];
    logic        err_s   [3];
    logic        busy_s  [3];
    logic        done_s  [3];

    int lat_t [3] = '{2, 0, 2};
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ready_cyc [3] = '{0, 0, 0};

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        int          idx;
        bit          w;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vecs [19];

    mem_responder #(.LATENCY(2), .DEPTH(256)) u_dut (
        .clock(clock), .reset_n(reset_n), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .clear(clear_s[0]), .ready(ready_s[0]), .rdata(rdata_s[0]),
        .err(err_s[0]), .busy(busy_s[0]), .clear_done(done_s[0]));

    mem_responder #(.LATENCY(0), .DEPTH(256)) u_lat0 (
        .clock(clock), .reset_n(reset_n), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .clear(clear_s[1]), .ready(ready_s[1]), .rdata(rdata_s[1]),
        .err(err_s[1]), .busy(busy_s[1]), .clear_done(done_s[1]));

    mem_responder #(.LATENCY(2), .DEPTH(200)) u_d200 (
        .clock(clock), .reset_n(reset_n), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .clear(clear_s[2]), .ready(ready_s[2]), .rdata(rdata_s[2]),
        .err(err_s[2]), .busy(busy_s[2]), .clear_done(done_s[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request in an IDLE cycle, optionally pulsing clear while it is in flight.
    task automatic do_txn(input int idx, input bit w, input logic [7:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input logic exp_err, input int clr_n,
                          input string tag);
        exp_t e;
        bit   got;
        int   lat_meas;
        got      = 1'b0;
        lat_meas = 0;
        @(posedge clock); #1;
        req_s[idx]   = 1'b1;
        we_s[idx]    = w;
        addr_s[idx]  = a;
        wdata_s[idx] = d;
        sb.push_back('{exp_rd, exp_err, lat_t[idx] + 1});
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock); #1;
            if (n == 1) req_s[idx] = 1'b0;
            clear_s[idx] = (n <= clr_n);
            if (ready_s[idx]) begin
                got      = 1'b1;
                lat_meas = n;
                break;
            end
        end
        clear_s[idx] = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            ready_cyc[idx] = cyc;
            chk({tag, "_lat"}, lat_meas, e.lat);
            chk({tag, "_err"}, {31'd0, err_s[idx]}, {31'd0, e.err});
            chk({tag, "_rdata"}, {16'd0, rdata_s[idx]}, {16'd0, e.rdata});
        end
    endtask

    initial begin
        int busy_cnt, done_cnt, rdy_cnt, overlap, prev;

        vecs[0]  = '{0, 1'b1, 8'hA5, 16'h1234, 16'h0000, 1'b0};
        vecs[1]  = '{0, 1'b0, 8'hA5, 16'h0000, 16'h1234, 1'b0};
        vecs[2]  = '{0, 1'b1, 8'h00, 16'hBEEF, 16'h1234, 1'b0};
        vecs[3]  = '{0, 1'b1, 8'hFF, 16'h0F0F, 16'h1234, 1'b0};
        vecs[4]  = '{0, 1'b0, 8'h00, 16'h0000, 16'hBEEF, 1'b0};
        vecs[5]  = '{0, 1'b0, 8'hFF, 16'h0000, 16'h0F0F, 1'b0};
        vecs[6]  = '{0, 1'b1, 8'hA5, 16'h5A5A, 16'h0F0F, 1'b0};
        vecs[7]  = '{0, 1'b0, 8'hA5, 16'h0000, 16'h5A5A, 1'b0};
        vecs[8]  = '{2, 1'b1, 8'hC7, 16'h7777, 16'h0000, 1'b0};
        vecs[9]  = '{2, 1'b1, 8'hC8, 16'hFFFF, 16'h0000, 1'b1};
        vecs[10] = '{2, 1'b0, 8'hC8, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{2, 1'b0, 8'hC7, 16'h0000, 16'h7777, 1'b0};
        vecs[12] = '{2, 1'b1, 8'hC8, 16'h1234, 16'h7777, 1'b1};
        vecs[13] = '{2, 1'b0, 8'hC7, 16'h0000, 16'h7777, 1'b0};
        vecs[14] = '{2, 1'b0, 8'hFF, 16'h0000, 16'h0000, 1'b1};
        vecs[15] = '{1, 1'b1, 8'h10, 16'h1111, 16'h0000, 1'b0};
        vecs[16] = '{1, 1'b0, 8'h10, 16'h0000, 16'h1111, 1'b0};
        vecs[17] = '{1, 1'b1, 8'h11, 16'h2222, 16'h1111, 1'b0};
        vecs[18] = '{1, 1'b0, 8'h11, 16'h0000, 16'h2222, 1'b0};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0; clear_s[i] = 1'b0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_ready", i), {31'd0, ready_s[i]}, 0);
            chk($sformatf("rst%0d_err", i), {31'd0, err_s[i]}, 0);
            chk($sformatf("rst%0d_busy", i), {31'd0, busy_s[i]}, 0);
            chk($sformatf("rst%0d_done", i), {31'd0, done_s[i]}, 0);
            chk($sformatf("rst%0d_rdata", i), {16'd0, rdata_s[i]}, 0);
        end

        for (int i = 0; i < 19; i++) begin
            prev = ready_cyc[vecs[i].idx];
            do_txn(vecs[i].idx, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].exp_err,
                   0, $sformatf("vec%0d", i));
            if (i > 0 && vecs[i-1].idx == vecs[i].idx)
                chk($sformatf("vec%0d_gap", i), ready_cyc[vecs[i].idx] - prev,
                    lat_t[vecs[i].idx] + 2);
        end

        // Two clear pulses during a read: read completes, then exactly one sweep.
        do_txn(0, 1'b0, 8'hA5, 16'h0, 16'h5A5A, 1'b0, 2, "rd_clr");
        busy_cnt = 0; done_cnt = 0; overlap = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1;
            if (busy_s[0]) busy_cnt++;
            if (done_s[0]) done_cnt++;
            if (done_s[0] && busy_s[0]) overlap++;
        end
        chk("clr_busy_cycles", busy_cnt, 256);
        chk("clr_done_pulses", done_cnt, 1);
        chk("clr_done_busy_overlap", overlap, 0);
        do_txn(0, 1'b0, 8'h00, 16'h0, 16'h0000, 1'b0, 0, "clr_rd00");
        do_txn(0, 1'b0, 8'hFF, 16'h0, 16'h0000, 1'b0, 0, "clr_rdFF");

        // req and clear together: clear only; a req during the sweep is ignored.
        @(posedge clock); #1;
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 8'h00; clear_s[0] = 1'b1;
        rdy_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin req_s[0] = 1'b0; clear_s[0] = 1'b0; end
            if (k == 5) req_s[0] = 1'b1;
            if (k == 6) req_s[0] = 1'b0;
            if (ready_s[0]) rdy_cnt++;
            if (done_s[0]) done_cnt++;
            if (busy_s[0]) busy_cnt++;
        end
        chk("conf_ready_pulses", rdy_cnt, 0);
        chk("conf_done_pulses", done_cnt, 1);
        chk("conf_busy_cycles", busy_cnt, 256);

        // Reset ten cycles into a sweep: low words cleared, high words intact.
        do_txn(0, 1'b1, 8'h80, 16'hC0DE, 16'h0000, 1'b0, 0, "pre_w80");
        do_txn(0, 1'b1, 8'h05, 16'h0505, 16'h0000, 1'b0, 0, "pre_w05");
        do_txn(0, 1'b0, 8'h80, 16'h0, 16'hC0DE, 1'b0, 0, "pre_r80");
        @(posedge clock); #1;
        clear_s[0] = 1'b1;
        @(posedge clock); #1;
        clear_s[0] = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("midclr_busy", {31'd0, busy_s[0]}, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready_s[0]}, 0);
        chk("arst_err", {31'd0, err_s[0]}, 0);
        chk("arst_busy", {31'd0, busy_s[0]}, 0);
        chk("arst_done", {31'd0, done_s[0]}, 0);
        chk("arst_rdata", {16'd0, rdata_s[0]}, 0);
        @(negedge clock) reset_n = 1'b1;
        do_txn(0, 1'b0, 8'h05, 16'h0, 16'h0000, 1'b0, 0, "post_r05");
        do_txn(0, 1'b0, 8'h80, 16'h0, 16'hC0DE, 1'b0, 0, "post_r80");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
